// File: rtl/gate_exerciser_pkg.sv
// Shared state encodings and counter width for the lab gate testers.
// No logic; constants only.
// Not applicable: no datapath or flow control.
package gate_exerciser_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_APPLY  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int SETTLE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_APPLY  = ST_APPLY,
        S_SETTLE = ST_SETTLE,
        S_SAMPLE = ST_SAMPLE,
        S_DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/gate_exerciser_settle_timer.sv
// Loadable down-counter with zero flag; stops at zero.
// Latency: load/decrement visible one cycle later, zero flag is combinational from the count.
// Backpressure: none; load has priority over decrement.
module settle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_exerciser.sv
// Drives every input vector into a gate, samples after a settle time, checks against EXPECTED (GATE_EXERCISER_SYNC_EN adds a 2-flop input synchronizer).
// Latency: done at 2**N_IN*(SETTLE_CYCLES+2)+1 cycles after start (+2 per vector with sync).
// Backpressure: start is ignored while busy; no queueing.
module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int                     N_IN          = 2,
    parameter int                     SETTLE_CYCLES = 4,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED      = 4'b1110
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [N_IN-1:0]        stim,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   fail_vec,
    output logic [N_IN:0]          err_count
);

    localparam int NV = 1 << N_IN;

    logic obs;

`ifdef GATE_EXERCISER_SYNC_EN
    // Extra bit so SETTLE_CYCLES+1 still fits when SETTLE_CYCLES is 255.
    localparam int                CNT_W    = SETTLE_W + 1;
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(SETTLE_CYCLES + 1);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], dut_out};
        end
    end

    assign obs = sync_q[1];
`else
    localparam int                CNT_W    = SETTLE_W;
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    assign obs = dut_out;
`endif

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [NV-1:0]   fail_q, fail_d;
    logic [N_IN:0]   err_q, err_d;
    logic            pass_q, pass_d;
    logic            tmr_load, tmr_dec, tmr_zero;

    settle_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (LOAD_VAL),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stim_d   = stim_q;
        fail_d   = fail_q;
        err_d    = err_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_APPLY;
                    idx_d   = '0;
                    fail_d  = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                stim_d   = idx_q;
                tmr_load = 1'b1;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (tmr_zero) begin
                    state_d = S_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_SAMPLE: begin
                if (obs != EXPECTED[idx_q]) begin
                    fail_d[idx_q] = 1'b1;
                    err_d         = err_q + 1'b1;
                end
                if (&idx_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_APPLY;
                end
            end
            S_DONE: begin
                pass_d  = (fail_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            stim_q  <= '0;
            fail_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stim_q  <= stim_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign stim      = stim_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign fail_vec  = fail_q;
    assign err_count = err_q;

endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Synthesizable hardware tester that drives every input combination into a small combinational gate under test, such as the lab OR gate.
- For each combination it waits a settle interval, samples the gate output and compares it against a parameterized truth table.
- It reports per-vector failures, an error count and pass/fail. This is the driving and checking end of the gate interface, so a gate can be self-tested on the board without a simulator.

Parameters:
- N_IN, 2: number of gate inputs; 2**N_IN vectors are applied.
- SETTLE_CYCLES, 4: clock cycles between driving a vector and sampling; legal range is 1 to 255.
- EXPECTED, 4'b1110: truth table, width 2**N_IN; bit i is the expected output for stim == i. The default is OR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- stim  out  N_IN  drives the gate inputs; stim[0]=a, stim[1]=b.
- dut_out  in  1  gate output under test.
- busy  out  1  high from the first APPLY through the DONE cycle.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  high when the last completed run had zero mismatches; held until the next start.
- fail_vec  out  2**N_IN  bit i set when vector i mismatched; held until the next start.
- err_count  out  N_IN+1  number of mismatches in the last run; held until the next start.

Behaviour:
- Reset is asynchronous and active-high. On rst, all outputs go to 0 immediately: stim=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0. State returns to IDLE, the vector index to 0 and the settle counter to 0. Reset mid-run aborts the run with no done pulse.
- FSM states and transitions:
  - IDLE: on start=1 at a clock edge, go to APPLY. On that same edge, clear fail_vec, err_count and pass, and set idx=0.
  - APPLY (1 cycle): stim <= idx; busy=1; go to SETTLE with settle counter = SETTLE_CYCLES-1.
  - SETTLE: decrement the counter each cycle; when the counter is 0, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
  - SAMPLE (1 cycle): if dut_out != EXPECTED[idx], set fail_vec[idx] and increment err_count. If idx == 2**N_IN-1, go to DONE; otherwise idx <= idx+1 and go to APPLY.
  - DONE (1 cycle): done=1; pass = (fail_vec==0), using the final SAMPLE result; busy=1; go to IDLE.
- stim holds the last applied vector after a run and returns to 0 only on reset.
- Latency: done asserts 2**N_IN*(SETTLE_CYCLES+2)+1 cycles after the edge that samples start. With the defaults this is 25 cycles.
- start while busy is ignored; there is no queueing. start held high in IDLE starts back-to-back runs, and each new run clears the previous results.
- err_count cannot overflow, since its maximum is 2**N_IN.

Optional Feature:
- Macro: GATE_EXERCISER_SYNC_EN.
- Defined: dut_out passes through a 2-flop synchronizer (reset to 0) before comparison. SETTLE lasts SETTLE_CYCLES+2 cycles, so latency becomes 2**N_IN*(SETTLE_CYCLES+4)+1.
- Undefined: dut_out is compared directly in SAMPLE, and latency is as stated in Behaviour.

Decomposition:
- Shared include file holds the state encodings as localparams (IDLE=0, APPLY=1, SETTLE=2, SAMPLE=3, DONE=4, 3 bits) and the SETTLE width constant (8).
- Sub-module settle_timer: loadable down-counter with a zero flag, reused by later lab testers.
- The FSM, index register and result registers live in gate_exerciser.

Test Plan:
- Bench model is a correct OR gate, defaults used. Pulse start -> stim steps 0,1,2,3; done occurs at cycle 25 after start; pass=1, fail_vec=4'b0000, err_count=0.
- Stuck-at-0 model (dut_out=0). Run -> fail_vec=4'b1110, err_count=3, pass=0.
- AND-gate model with EXPECTED=OR. Run -> fail_vec=4'b0110, err_count=2, pass=0.
- Pulse start again at cycle 10 of a run -> no restart; done still at cycle 25; results unchanged from a single run.
- Assert rst at cycle 12 of a run -> all outputs 0 immediately and no done pulse. A new start afterwards gives a full correct run with pass=1.
- Build with GATE_EXERCISER_SYNC_EN and a correct OR model -> done at cycle 4*(4+4)+1=33; pass=1.
